// File: rtl/display_pkg.sv
// display_pkg: shared constants, types and helpers for the display scan path.
//   BLANK_CODE   : BCD bus code rendered as an unlit digit by the decoder.
//   conv_state_t : binary-to-BCD conversion FSM states.
//   pow10(n)     : 10^n, used to derive the overflow limit at elaboration.
package display_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary to packed BCD.
//   clk, reset : clock, asynchronous active-high reset
//   start      : sample bin and begin a conversion (ignored unless idle)
//   bin        : unsigned binary input
//   busy       : high for DATA_W cycles, starting one cycle after start
//   done       : high during the commit cycle; bcd is final then
//   bcd        : packed BCD accumulator, N_DIGITS nibbles
//   ovf        : last converted value was >= 10^N_DIGITS
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  ovf
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = pow10(N_DIGITS);

  conv_state_t       state;
  logic [DATA_W-1:0] bin_r;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt;
  logic              ovf_next;

  // Add-3 correction on every nibble that would reach >= 10 after doubling.
  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  assign done = (state == COMMIT);
  assign bcd  = acc;

  // busy is registered from the SHIFT state so it trails start by one cycle
  // and drops on the same edge that commits the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bin_r    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            bin_r    <= bin;
            acc      <= '0;
            cnt      <= CW'(DATA_W);
            ovf_next <= (64'(bin) >= LIMIT);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          busy  <= 1'b1;
          acc   <= {adj[BW-2:0], bin_r[DATA_W-1]};
          bin_r <= {bin_r[DATA_W-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          ovf   <= ovf_next;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: converts a binary result to BCD and time-multiplexes the
// digits onto a shared 4-bit bus with active-low one-hot digit enables.
//   clk, reset : clock, asynchronous active-high reset
//   value      : unsigned binary value to display
//   load       : single-cycle strobe sampling value (ignored while converting)
//   busy       : conversion in progress
//   ovf        : last loaded value was >= 10^N_DIGITS (display fully blanked)
//   digit_bcd  : BCD code of the active digit, BLANK_CODE when blanked
//   digit_an   : active-low one-hot enable, bit 0 = rightmost digit
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   value,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [3:0]          digit_bcd,
  output logic [N_DIGITS-1:0] digit_an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  conv_done;
  logic [4*N_DIGITS-1:0] conv_bcd;
  logic [4*N_DIGITS-1:0] disp;
  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic                  tc;
  logic [3:0]            code;
  logic [3:0]            nib;
  logic                  upper_nz;

  bin2bcd_seq #(
    .N_DIGITS(N_DIGITS),
    .DATA_W  (DATA_W)
  ) u_conv (
    .clk  (clk),
    .reset(reset),
    .start(load),
    .bin  (value),
    .busy (busy),
    .done (conv_done),
    .bcd  (conv_bcd),
    .ovf  (ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp <= '0;
    end else if (conv_done) begin
      disp <= conv_bcd;
    end
  end

  always_comb begin
    tc       = (presc == PW'(SCAN_DIV - 1));
    idx_next = idx;
    if (tc) begin
      idx_next = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Output registers are fed from the next index so enable and data switch
  // together and each digit is held for exactly SCAN_DIV cycles.
  always_comb begin
    nib      = '0;
    upper_nz = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (IW'(j) == idx_next) begin
        nib = disp[4*j +: 4];
      end
      if ((IW'(j) >= idx_next) && (disp[4*j +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
    if (ovf) begin
      code = BLANK_CODE;
    end else if ((idx_next != '0) && !upper_nz) begin
      code = BLANK_CODE;
    end else begin
      code = nib;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      idx       <= '0;
      digit_an  <= ~N_DIGITS'(1);
      digit_bcd <= 4'h0;
    end else begin
      presc     <= tc ? '0 : presc + 1'b1;
      idx       <= idx_next;
      digit_an  <= ~(N_DIGITS'(1) << idx_next);
      digit_bcd <= code;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with SCAN_DIV=4: the stimulus pushes
// the expected display (from a decimal arithmetic model) per load, and a
// monitor checks busy length, ovf and a full scan frame after each commit.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int W  = 14;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] value;
  logic         load;
  logic         busy;
  logic         ovf;
  logic [3:0]   digit_bcd;
  logic [N-1:0] digit_an;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .N_DIGITS(N),
    .DATA_W  (W),
    .SCAN_DIV(SD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .ovf      (ovf),
    .digit_bcd(digit_bcd),
    .digit_an (digit_an)
  );

  typedef struct {
    logic         ovf;
    logic [4*N-1:0] dig;
    bit           chk_len;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   frames_done = 0;
  int   req_cnt = 0;
  bit   mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference: digit i = (v / 10^i) % 10, blank above the MSD, all
  // blank when v does not fit in N digits.
  function automatic exp_t model(input int unsigned v, input bit chk_len);
    exp_t e;
    int unsigned p;
    e.ovf = (v >= 10 ** N);
    e.chk_len = chk_len;
    e.dig = '0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      if (e.ovf || (i > 0 && v < p)) e.dig[4*i +: 4] = 4'hF;
      else                           e.dig[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return e;
  endfunction

  function automatic int active_idx(input logic [N-1:0] an);
    int k;
    int ones;
    k = -1;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      if (an[i] === 1'b0) begin
        ones++;
        k = i;
      end
    end
    return (ones == 1) ? k : -1;
  endfunction

  // Monitor: triggered by busy falling or by an explicit frame request.
  initial begin
    bit   prev_busy;
    int   bcnt;
    int   seen_req;
    bit   from_busy;
    int   k;
    exp_t e;
    prev_busy = 1'b0;
    bcnt = 0;
    seen_req = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        prev_busy = 1'b0;
        bcnt = 0;
      end else begin
        from_busy = prev_busy && !busy;
        if (busy) bcnt++;
        prev_busy = busy;
        if (from_busy || (req_cnt != seen_req)) begin
          seen_req = req_cnt;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: output with no expected entry at %0t", $time);
          end else begin
            e = q.pop_front();
            if (e.chk_len) check("busy_len", bcnt, W);
            bcnt = 0;
            check("ovf", ovf, e.ovf);
            if (from_busy) @(negedge clk);
            for (int s = 0; s < N * SD; s++) begin
              if (s > 0) @(negedge clk);
              k = active_idx(digit_an);
              check("an_onehot", (k >= 0), 1);
              if (k >= 0) check("digit_bcd", digit_bcd, e.dig[4*k +: 4]);
            end
          end
          frames_done++;
        end
      end
    end
  end

  // Scan timing checker: each digit held SD cycles, index advances by one.
  initial begin
    int prevk;
    int run;
    bit partial;
    int k;
    prevk = -1;
    run = 0;
    partial = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevk = -1;
        partial = 1'b1;
      end else begin
        k = active_idx(digit_an);
        if (k != prevk) begin
          if (prevk >= 0 && !partial) begin
            check("scan_len", run, SD);
            check("scan_order", k, (prevk + 1) % N);
          end else if (prevk >= 0) begin
            partial = 1'b0;
          end
          prevk = k;
          run = 1;
        end else begin
          run++;
        end
      end
    end
  end

  task automatic wait_frame();
    int target;
    target = frames_done + 1;
    for (int c = 0; c < 300 && frames_done < target; c++) @(posedge clk);
    if (frames_done < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: frames_done=%0d, expected %0d", frames_done, target);
    end
  endtask

  task automatic do_load(input int unsigned v, input int ign_cycle, input int unsigned ign_v);
    q.push_back(model(v, 1'b1));
    @(posedge clk); #1;
    value = W'(v);
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    if (ign_cycle > 0) begin
      repeat (ign_cycle - 1) @(posedge clk);
      #1;
      value = W'(ign_v);
      load  = 1'b1;
      @(posedge clk); #1;
      load  = 1'b0;
    end
    wait_frame();
  endtask

  initial begin
    int unsigned rv;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_an", digit_an, 4'b1110);
    check("rst_bcd", digit_bcd, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

    // Idle display after reset.
    q.push_back(model(0, 1'b0));
    req_cnt++;
    wait_frame();

    do_load(1234, 0, 0);
    do_load(7, 0, 0);
    do_load(1005, 0, 0);
    do_load(10000, 0, 0);
    do_load(9999, 0, 0);
    do_load(42, 5, 55);
    for (int i = 0; i < 8; i++) begin
      rv = $urandom_range(0, (1 << W) - 1);
      if (i % 3 == 0) rv = $urandom_range(0, 99);
      if (i % 2 == 0) do_load(rv, 0, 0);
      else            do_load(rv, $urandom_range(1, W), $urandom_range(0, (1 << W) - 1));
    end

    // Asynchronous reset in the middle of a conversion.
    mon_en = 1'b0;
    @(posedge clk); #1;
    value = W'(1234);
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ovf", ovf, 0);
    check("arst_an", digit_an, 4'b1110);
    check("arst_bcd", digit_bcd, 4'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;
    q.push_back(model(0, 1'b0));
    req_cnt++;
    wait_frame();

    repeat (2 * N * SD) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
